cpu_controller: RTL and testbench

Instruction-sequencing controller for the 16-bit register/ALU datapath. It latches a 16-bit instruction and decodes it. A Moore state machine then drives the datapath's register-file, pipeline-register, mux and ALU controls over several cycles to execute one instruction per `s` start pulse. It sits between the switch/top-level glue and the datapath, and adds no arithmetic of its own beyond immediate sign extension.

---
 rtl/cpu_controller_if.sv | 33 +++
 rtl/cpu_controller.sv | 137 +++++++++++++
 tb/tb_cpu_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_if.sv
// Control bundle between the switch/top-level glue, the controller and the datapath.
// Handshake: the glue drives s/load/in; the controller reports w=1 while idle in WAIT.
interface cpu_controller_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [15:0] datapath_in;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;

  modport master (
    output s, load, in,
    input  w, datapath_in, writenum, readnum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop
  );

  modport slave (
    input  s, load, in,
    output w, datapath_in, writenum, readnum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop
  );
endinterface

// File: rtl/cpu_controller.sv
// Instruction sequencer: latches one 16-bit instruction and walks a Moore FSM that
// drives register-file, pipeline-register, mux and ALU controls of the datapath.
module cpu_controller (
  input  logic               clk,
  input  logic               reset,
  cpu_controller_if.slave    bus,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_RD  = 3'd6
  } state_t;

  typedef struct packed {
    logic       w;
    logic [2:0] writenum;
    logic [2:0] readnum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctrl_t;

  state_t      r_state;
  logic [15:0] r_ir;
  ctrl_t       r_ctrl;

  state_t      w_next_state;
  logic [15:0] w_next_ir;
  logic [4:0]  w_opcode_op;

  assign w_opcode_op = r_ir[15:11];

  // Control word for a state given the instruction it is executing.
  function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      S_WAIT:      c.w = 1'b1;
      S_WRITE_IMM: begin
        c.vsel     = 1'b1;
        c.write    = 1'b1;
        c.writenum = ir[10:8];
      end
      S_GET_A: begin
        c.readnum = ir[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = ir[2:0];
        c.loadb   = 1'b1;
      end
      S_ALU: begin
        c.shift = ir[4:3];
        if (ir[15:13] == 3'b110) begin
          // MOV reg runs through the ALU as 0 + shifted Rm.
          c.asel  = 1'b1;
          c.loadc = 1'b1;
        end else begin
          c.aluop = ir[12:11];
          if (ir[12:11] == 2'b01) c.loads = 1'b1;
          else                    c.loadc = 1'b1;
        end
      end
      S_WRITE_RD: begin
        c.write    = 1'b1;
        c.writenum = ir[7:5];
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next_ir    = (r_state == S_WAIT && bus.load) ? bus.in : r_ir;
    w_next_state = r_state;
    case (r_state)
      S_WAIT:      if (bus.s) w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_opcode_op)
          5'b110_10:                      w_next_state = S_WRITE_IMM;
          5'b110_00, 5'b101_11:           w_next_state = S_GET_B;
          5'b101_00, 5'b101_01, 5'b101_10: w_next_state = S_GET_A;
          default:                        w_next_state = S_WAIT;
        endcase
      end
      S_WRITE_IMM: w_next_state = S_WAIT;
      S_GET_A:     w_next_state = S_GET_B;
      S_GET_B:     w_next_state = S_ALU;
      S_ALU:       w_next_state = (w_opcode_op == 5'b101_01) ? S_WAIT : S_WRITE_RD;
      S_WRITE_RD:  w_next_state = S_WAIT;
      default:     w_next_state = S_WAIT;
    endcase
  end

  // Outputs are registered from the destination state so they stay glitch-free Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= 16'h0000;
      r_ctrl  <= ctrl_for(S_WAIT, 16'h0000);
    end else begin
      r_state <= w_next_state;
      r_ir    <= w_next_ir;
      r_ctrl  <= ctrl_for(w_next_state, w_next_ir);
    end
  end

  assign bus.datapath_in = {{8{r_ir[7]}}, r_ir[7:0]};
  assign bus.w           = r_ctrl.w;
  assign bus.writenum    = r_ctrl.writenum;
  assign bus.readnum     = r_ctrl.readnum;
  assign bus.write       = r_ctrl.write;
  assign bus.loada       = r_ctrl.loada;
  assign bus.loadb       = r_ctrl.loadb;
  assign bus.loadc       = r_ctrl.loadc;
  assign bus.loads       = r_ctrl.loads;
  assign bus.asel        = r_ctrl.asel;
  assign bus.bsel        = r_ctrl.bsel;
  assign bus.vsel        = r_ctrl.vsel;
  assign bus.shift       = r_ctrl.shift;
  assign bus.ALUop       = r_ctrl.aluop;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed test-plan sequences followed by random cycles,
// every cycle compared against a per-instruction schedule model.
module tb_cpu_controller;

  localparam int VW = 35;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  cpu_controller_if bus();

  cpu_controller dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0]   m_ir;
  logic [VW-1:0] exp_q[$];

  function automatic logic [15:0] sx8(input logic [15:0] ir);
    return {{8{ir[7]}}, ir[7:0]};
  endfunction

  // {w, datapath_in, writenum, readnum, write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop}
  function automatic logic [VW-1:0] vec(
    input logic w, input logic [2:0] wn, input logic [2:0] rn,
    input logic wr, input logic la, input logic lb, input logic lc, input logic ls,
    input logic as, input logic vs, input logic [1:0] sh, input logic [1:0] op,
    input logic [15:0] dp);
    return {w, dp, wn, rn, wr, la, lb, lc, ls, as, 1'b0, vs, sh, op};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.w, bus.datapath_in, bus.writenum, bus.readnum, bus.write, bus.loada,
            bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel, bus.vsel, bus.shift, bus.ALUop};
  endfunction

  task automatic check_vec(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle outputs for one instruction, starting with the decode cycle.
  task automatic push_schedule(input logic [15:0] ir);
    logic [15:0] dp;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh, op;
    logic [VW-1:0] dec, get_a, get_b, wr_rd;
    dp = sx8(ir);
    rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0]; op = ir[12:11];
    dec   = vec(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp);
    get_a = vec(0, 0, rn, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp);
    get_b = vec(0, 0, rm, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, dp);
    wr_rd = vec(0, rd, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, dp);
    exp_q.push_back(dec);
    case (ir[15:11])
      5'b11010: exp_q.push_back(vec(0, rn, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, dp));
      5'b11000: begin
        exp_q.push_back(get_b);
        exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, sh, 2'b00, dp));
        exp_q.push_back(wr_rd);
      end
      5'b10111: begin
        exp_q.push_back(get_b);
        exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, sh, 2'b11, dp));
        exp_q.push_back(wr_rd);
      end
      5'b10100, 5'b10110: begin
        exp_q.push_back(get_a);
        exp_q.push_back(get_b);
        exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, sh, op, dp));
        exp_q.push_back(wr_rd);
      end
      5'b10101: begin
        exp_q.push_back(get_a);
        exp_q.push_back(get_b);
        exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, sh, 2'b01, dp));
      end
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs, advance the model, then compare outputs at the falling edge.
  task automatic step(input logic rst, input logic sv, input logic ld,
                      input logic [15:0] iv, input string tag);
    logic [VW-1:0] exp;
    reset    = rst;
    bus.s    = sv;
    bus.load = ld;
    bus.in   = iv;
    @(posedge clk);
    if (rst) begin
      m_ir = 16'h0000;
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (ld) m_ir = iv;
      if (sv) push_schedule(m_ir);
    end else begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    if (exp_q.size() != 0) exp = exp_q[0];
    else                   exp = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, sx8(m_ir));
    check_vec(tag, dut_vec(), exp);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [10:0] f;
    f = 11'($urandom_range(0, 2047));
    case ($urandom_range(0, 6))
      0: return {5'b11010, f};
      1: return {5'b11000, f};
      2: return {5'b10100, f};
      3: return {5'b10101, f};
      4: return {5'b10110, f};
      5: return {5'b10111, f};
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    m_ir     = 16'h0000;
    reset    = 1'b1;
    bus.s    = 1'b0;
    bus.load = 1'b0;
    bus.in   = 16'h0000;
    @(negedge clk);

    step(1, 0, 0, 16'h0000, "reset");
    step(1, 1, 1, 16'hA148, "reset_ignores_inputs");
    step(0, 0, 0, 16'h0000, "idle");

    // MOV R0,#-10
    step(0, 1, 1, 16'hD0F6, "movimm");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0000, "movimm");

    // ADD R2,R1,R0,LSL#1
    step(0, 1, 1, 16'hA148, "add");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 16'h0000, "add");

    // CMP R1,R1
    step(0, 1, 1, 16'hA901, "cmp");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0000, "cmp");

    // MOV R3,R5
    step(0, 1, 1, 16'hC065, "movreg");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0000, "movreg");

    // MVN R4,R6,LSR#1
    step(0, 1, 1, 16'hB896, "mvn");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0000, "mvn");

    // Undefined encoding
    step(0, 1, 1, 16'hE000, "undef");
    for (int i = 0; i < 2; i++) step(0, 0, 0, 16'h0000, "undef");

    // Reset while ADD sits in GET_B
    step(0, 1, 1, 16'hA148, "rst_mid");
    step(0, 0, 0, 16'h0000, "rst_mid");
    step(0, 0, 0, 16'h0000, "rst_mid");
    step(1, 0, 0, 16'h0000, "rst_mid_reset");
    step(0, 0, 0, 16'h0000, "rst_mid_after");

    // Load attempts mid-instruction must not disturb the IR
    step(0, 1, 1, 16'hA148, "ign_load");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'hD07F, "ign_load");
    step(0, 0, 0, 16'h0000, "ign_load");
    step(0, 1, 0, 16'h0000, "reexec");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0000, "reexec");

    // s held high: back-to-back re-execution
    step(0, 1, 1, 16'hD285, "hold_s");
    for (int i = 0; i < 9; i++) step(0, 1, 0, 16'h0000, "hold_s");
    step(0, 1, 1, 16'hA901, "hold_s_cmp");
    for (int i = 0; i < 12; i++) step(0, 1, 0, 16'h0000, "hold_s_cmp");

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1), rand_instr(), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
